// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with occupancy flags, optional FWFT read, flush and sticky error flags
module sync_fifo_param #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr_i,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     rd_valid_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     almost_full_o,
  output logic                     almost_empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o,
  underflow_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH must be a power of two >= 2");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH || AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_thresh
    $error("sync_fifo_param: threshold out of range");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d, count_q, count_d;
  logic             ovf_q, ovf_d, unf_q, unf_d, rd_valid_q, rd_valid_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_acc, wr_acc;
  logic [WIDTH-1:0] head;

  assign head           = mem[rptr_q[AW-1:0]];
  assign full_o         = count_q == PW'(DEPTH);
  assign empty_o        = count_q == '0;
  assign almost_full_o  = count_q >= PW'(AF_THRESH);
  assign almost_empty_o = count_q <= PW'(AE_THRESH);
  assign count_o        = count_q;
  assign overflow_o     = ovf_q;
  assign underflow_o    = unf_q;
  assign rd_valid_o     = (FWFT != 0) ? ~empty_o : rd_valid_q;
  assign rd_data_o      = (FWFT != 0) ? (empty_o ? '0 : head) : rd_data_q;

  // accept logic and next state; flush overrides any request in the same cycle
  always_comb begin
    rd_acc     = rd_en_i & ~empty_o;
    wr_acc     = wr_en_i & (~full_o | rd_acc);
    wptr_d     = clr_i ? '0 : wptr_q + PW'(wr_acc);
    rptr_d     = clr_i ? '0 : rptr_q + PW'(rd_acc);
    count_d    = clr_i ? '0 : count_q + PW'(wr_acc) - PW'(rd_acc);
    ovf_d      = ~clr_i & (ovf_q | (wr_en_i & ~wr_acc));
    unf_d      = ~clr_i & (unf_q | (rd_en_i & ~rd_acc));
    rd_valid_d = ~clr_i & rd_acc;
    rd_data_d  = (~clr_i & rd_acc) ? head : rd_data_q;
  end

  // control state with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // storage array, not reset, written only by an accepted write
  always_ff @(posedge clk) begin
    if (rst_n && wr_acc && !clr_i) mem[wptr_q[AW-1:0]] <= wr_data_i;
  end
endmodule
